// File: rtl/rtc_bcd_time_decoder.sv
// rtl/rtc_bcd_time_decoder.sv - RTC packed-BCD seconds/minutes/hours frame decoder
//
// Collects a three-byte read frame (seconds, minutes, hours) from an RTC,
// validates each packed-BCD byte, converts it to binary into shadow registers
// and commits all three values to the outputs together.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   start      - one-cycle pulse opening a new frame
//   data_in    - packed BCD byte (tens [7:4], units [3:0])
//   data_valid - data_in qualifier
//   ready      - high while a frame byte can be accepted
//   sec_bin    - committed seconds, 0-59
//   min_bin    - committed minutes, 0-59
//   hour_bin   - committed hours, 0-23
//   done       - one-cycle pulse after a successful commit
//   err        - sticky frame error (bad byte or inter-byte timeout)
module rtc_bcd_time_decoder #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic [5:0] sec_bin,
    output logic [5:0] min_bin,
    output logic [4:0] hour_bin,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SEC,
        WAIT_MIN,
        WAIT_HOUR,
        COMMIT
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    // Timeout fires on the edge that would take the counter to TIMEOUT.
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   tcnt;
    logic [5:0]      sec_sh;
    logic [5:0]      min_sh;
    logic [4:0]      hour_sh;

    logic            in_wait;
    logic            start_frame;
    logic            accept;
    logic            timeout_hit;
    logic            byte_ok;
    logic [3:0]      tens;
    logic [3:0]      units;
    logic [7:0]      conv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        in_wait     = (state == WAIT_SEC) || (state == WAIT_MIN) || (state == WAIT_HOUR);
        ready       = in_wait;
        start_frame = start && (state != COMMIT);
        // start takes priority over a coincident byte, which is dropped.
        accept      = in_wait && data_valid && !start;
        timeout_hit = in_wait && !start && !accept && (tcnt == TLIM);

        // The seconds clock-halt bit is masked out of the tens nibble.
        units = data_in[3:0];
        tens  = (state == WAIT_SEC) ? {1'b0, data_in[6:4]} : data_in[7:4];
        conv  = {4'b0, tens} * 8'd10 + {4'b0, units};

        byte_ok = 1'b0;
        case (state)
            WAIT_SEC:  byte_ok = (units <= 4'd9) && (tens <= 4'd5);
            WAIT_MIN:  byte_ok = !data_in[7] && (units <= 4'd9) && (tens <= 4'd5);
            WAIT_HOUR: byte_ok = (data_in[7:6] == 2'b00) && (units <= 4'd9) &&
                                 ((tens < 4'd2) || ((tens == 4'd2) && (units <= 4'd3)));
            default:   byte_ok = 1'b0;
        endcase

        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_SEC;
                end
            end
            WAIT_SEC, WAIT_MIN, WAIT_HOUR: begin
                if (start) begin
                    state_next = WAIT_SEC;
                end else if (accept) begin
                    if (!byte_ok) begin
                        state_next = IDLE;
                    end else if (state == WAIT_SEC) begin
                        state_next = WAIT_MIN;
                    end else if (state == WAIT_MIN) begin
                        state_next = WAIT_HOUR;
                    end else begin
                        state_next = COMMIT;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt     <= '0;
            sec_sh   <= '0;
            min_sh   <= '0;
            hour_sh  <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            sec_bin  <= '0;
            min_bin  <= '0;
            hour_bin <= '0;
        end else begin
            if (start_frame || accept || timeout_hit) begin
                tcnt <= '0;
            end else if (in_wait) begin
                tcnt <= tcnt + CW'(1);
            end

            if (start_frame) begin
                sec_sh  <= '0;
                min_sh  <= '0;
                hour_sh <= '0;
            end else if (accept && byte_ok) begin
                case (state)
                    WAIT_SEC:  sec_sh  <= conv[5:0];
                    WAIT_MIN:  min_sh  <= conv[5:0];
                    WAIT_HOUR: hour_sh <= conv[4:0];
                    default:   ;
                endcase
            end

            if (start_frame) begin
                err <= 1'b0;
            end else if ((accept && !byte_ok) || timeout_hit) begin
                err <= 1'b1;
            end

            done <= (state == COMMIT);
            if (state == COMMIT) begin
                sec_bin  <= sec_sh;
                min_bin  <= min_sh;
                hour_bin <= hour_sh;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bcd_time_decoder.sv
// tb/tb_rtc_bcd_time_decoder.sv - scoreboard bench for rtc_bcd_time_decoder
module tb_rtc_bcd_time_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic [5:0] sec_bin;
    logic [5:0] min_bin;
    logic [4:0] hour_bin;
    logic       done;
    logic       err;

    rtc_bcd_time_decoder #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .sec_bin    (sec_bin),
        .min_bin    (min_bin),
        .hour_bin   (hour_bin),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic       e;
    } exp_t;

    exp_t       q[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [5:0] c_s = '0;
    logic [5:0] c_m = '0;
    logic [4:0] c_h = '0;

    function automatic logic [7:0] bcd(input logic [7:0] b);
        return {4'b0, b[7:4]} * 8'd10 + {4'b0, b[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ok(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
        logic [7:0] sv;
        logic [7:0] mv;
        logic [7:0] hv;
        sv  = bcd(s & 8'h7F);
        mv  = bcd(m);
        hv  = bcd(h);
        c_s = sv[5:0];
        c_m = mv[5:0];
        c_h = hv[4:0];
        q.push_back({c_s, c_m, c_h, 1'b0});
    endtask

    task automatic push_err();
        q.push_back({c_s, c_m, c_h, 1'b1});
    endtask

    task automatic check_outputs(input string tag);
        exp_t e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_sec"},  32'(sec_bin),  32'(e.s));
            chk({tag, "_min"},  32'(min_bin),  32'(e.m));
            chk({tag, "_hour"}, 32'(hour_bin), 32'(e.h));
            chk({tag, "_err"},  32'(err),      32'(e.e));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic frame_ok(input string tag, input bit do_start,
                            input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
        if (do_start) pulse_start();
        send_byte(s);
        send_byte(m);
        push_ok(s, m, h);
        send_byte(h);
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    task automatic frame_bad(input string tag, input logic [7:0] s,
                             input logic [7:0] m, input logic [7:0] h, input bit bad_min);
        pulse_start();
        send_byte(s);
        if (!bad_min) send_byte(m);
        push_err();
        send_byte(bad_min ? m : h);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, "_nodone"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        #1;
        q.push_back({6'd0, 6'd0, 5'd0, 1'b0});
        check_outputs("reset");
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_done",  32'(done),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // data_valid in IDLE is ignored
        send_byte(8'h45);
        chk("idle_ready", 32'(ready), 32'd0);
        q.push_back({6'd0, 6'd0, 5'd0, 1'b0});
        check_outputs("idle_ignore");

        frame_ok("normal", 1'b1, 8'h45, 8'h30, 8'h23);
        frame_ok("halt",   1'b1, 8'h92, 8'h00, 8'h07);
        frame_ok("normal2", 1'b1, 8'h45, 8'h30, 8'h23);
        frame_bad("bad_min",  8'h45, 8'h5A, 8'h00, 1'b1);
        frame_bad("bad_hour", 8'h45, 8'h30, 8'h24, 1'b0);

        // timeout: one byte, then idle cycles
        pulse_start();
        chk("to_err_cleared", 32'(err), 32'd0);
        send_byte(8'h10);
        repeat (7) @(negedge clk);
        chk("to_ready_before", 32'(ready), 32'd1);
        chk("to_err_before",   32'(err),   32'd0);
        @(negedge clk);
        chk("to_ready", 32'(ready), 32'd0);
        push_err();
        check_outputs("timeout");

        // restart and start/data_valid collision
        pulse_start();
        send_byte(8'h11);
        @(negedge clk);
        start      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'h22;
        @(negedge clk);
        start      = 1'b0;
        data_valid = 1'b0;
        chk("coll_ready", 32'(ready), 32'd1);
        chk("coll_err",   32'(err),   32'd0);
        frame_ok("restart", 1'b0, 8'h33, 8'h44, 8'h05);

        // reset in WAIT_HOUR
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        chk("mid_ready", 32'(ready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        c_s = '0;
        c_m = '0;
        c_h = '0;
        q.push_back({6'd0, 6'd0, 5'd0, 1'b0});
        check_outputs("async_reset");
        chk("async_ready", 32'(ready), 32'd0);
        chk("async_done",  32'(done),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_done",  32'(done),  32'd0);
        chk("post_reset_ready", 32'(ready), 32'd0);
        frame_ok("after_reset", 1'b1, 8'h59, 8'h59, 8'h23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
